// File: rtl/ifetch_if.sv
// Fetch-stage bundle: controller-facing instruction port plus program-memory read port.
// Pure wiring, no latency of its own.
// The master side is the fetch unit. The slave side is the controller and memory it talks to.
interface ifetch_if #(
    parameter int ADDR_W = 8
);
    // controller side
    logic              fetch;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic [7:0]        instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    // program memory side
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (
        input  fetch, jump, jump_addr, mem_ack, mem_rdata,
        output instr, instr_valid, pc, mem_req, mem_addr
    );

    modport slave (
        output fetch, jump, jump_addr, mem_ack, mem_rdata,
        input  instr, instr_valid, pc, mem_req, mem_addr
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: byte reads from program memory into a small prefetch queue whose head feeds ctrl.
// Latency: a byte acked at edge N is on instr/instr_valid in cycle N+1; one read outstanding at most.
// Backpressure: no new read starts while the queue is full; a pop reopens fetching on that same edge.
module ifetch #(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] head_pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [7:0]        q_dat [DEPTH];

    logic              fire;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_next;
    logic [ADDR_W-1:0] fetch_pc_inc;

    // Handshake events for this cycle; a jump suppresses both the push and the pop.
    always_comb begin
        fire         = mem_req_q && bus.mem_ack;
        push         = fire && (state == REQ) && !bus.jump;
        pop          = bus.fetch && (count != '0) && !bus.jump;
        fetch_pc_inc = fetch_pc + ADDR_W'(1);
        if (bus.jump) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Prefetch queue storage and head PC; a jump flushes and re-bases the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            head_pc <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                q_dat[i] <= 8'h00;
            end
        end else if (bus.jump) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            head_pc <= bus.jump_addr;
        end else begin
            count <= count_next;
            if (push) begin
                q_dat[wr_ptr] <= bus.mem_rdata;
                wr_ptr        <= (wr_ptr == LAST_P) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= (rd_ptr == LAST_P) ? '0 : rd_ptr + PTR_W'(1);
                head_pc <= head_pc + ADDR_W'(1);
            end
        end
    end

    // Request FSM: issues reads at fetch_pc, holds the address until ack, drains a stale read after a jump.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            fetch_pc   <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.jump) begin
                        state      <= REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= bus.jump_addr;
                        fetch_pc   <= bus.jump_addr;
                    end else if (count_next < DEPTH_C) begin
                        state      <= REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc;
                    end
                end
                REQ: begin
                    if (bus.jump) begin
                        fetch_pc <= bus.jump_addr;
                        if (bus.mem_ack) begin
                            // The acked byte belongs to the old stream; restart at the target.
                            mem_addr_q <= bus.jump_addr;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (bus.mem_ack) begin
                        fetch_pc <= fetch_pc_inc;
                        if (count_next < DEPTH_C) begin
                            mem_addr_q <= fetch_pc_inc;
                        end else begin
                            state     <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.jump) begin
                        fetch_pc <= bus.jump_addr;
                    end
                    if (bus.mem_ack) begin
                        state      <= REQ;
                        mem_addr_q <= bus.jump ? bus.jump_addr : fetch_pc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr       = q_dat[rd_ptr];
    assign bus.instr_valid = (count != '0);
    assign bus.pc          = head_pc;

endmodule
